// File: rtl/traffic_ctrl_timed.sv
// Highway/farm-road traffic light controller with built-in dwell timers,
// all-red clearance, early farm-green release and an emergency all-red override.
module traffic_ctrl_timed #(
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned HG_MIN = 8,
  parameter int unsigned Y_CYC  = 3,
  parameter int unsigned AR_CYC = 1,
  parameter int unsigned FG_MIN = 2,
  parameter int unsigned FG_MAX = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       C,
  input  logic       emg,
  output logic       HG,
  output logic       HY,
  output logic       HR,
  output logic       FG,
  output logic       FY,
  output logic       FR,
  output logic       ST,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    StHg  = 3'd0,
    StHy  = 3'd1,
    StHar = 3'd2,
    StFg  = 3'd3,
    StFy  = 3'd4,
    StFar = 3'd5,
    StEmg = 3'd6
  } state_e;

  localparam logic [CNT_W-1:0] HgLast  = CNT_W'(HG_MIN - 1);
  localparam logic [CNT_W-1:0] YLast   = CNT_W'(Y_CYC - 1);
  localparam logic [CNT_W-1:0] ArLast  = CNT_W'(AR_CYC - 1);
  localparam logic [CNT_W-1:0] FgFirst = CNT_W'(FG_MIN - 1);
  localparam logic [CNT_W-1:0] FgLast  = CNT_W'(FG_MAX - 1);
  localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             st_q;

  always_comb begin
    state_d = state_q;
    if (emg) begin
      state_d = StEmg;
    end else begin
      case (state_q)
        StHg:  if (cnt_q >= HgLast && C) state_d = StHy;
        StHy:  if (cnt_q == YLast) state_d = StHar;
        StHar: if (cnt_q == ArLast) state_d = StFg;
        // Farm green ends at its ceiling, or early once the side road empties.
        StFg:  if (cnt_q == FgLast || (cnt_q >= FgFirst && !C)) state_d = StFy;
        StFy:  if (cnt_q == YLast) state_d = StFar;
        StFar: if (cnt_q == ArLast) state_d = StHg;
        StEmg: state_d = StHg;
        default: state_d = StHg;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StHg;
      cnt_q   <= '0;
      st_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      st_q    <= (state_d != state_q);
    end
  end

  // Moore light decode; anything not a green/yellow phase shows red both ways.
  always_comb begin
    HG = 1'b0;
    HY = 1'b0;
    HR = 1'b1;
    FG = 1'b0;
    FY = 1'b0;
    FR = 1'b1;
    case (state_q)
      StHg: begin
        HG = 1'b1;
        HR = 1'b0;
      end
      StHy: begin
        HY = 1'b1;
        HR = 1'b0;
      end
      StFg: begin
        FG = 1'b1;
        FR = 1'b0;
      end
      StFy: begin
        FY = 1'b1;
        FR = 1'b0;
      end
      default: ;
    endcase
  end

  assign ST    = st_q;
  assign phase = state_q;

endmodule
